// File: rtl/demux_pkg.sv
// Shared constants for the data-routing demultiplexers: select width, port count
// and the select encodings for each output channel.
package demux_pkg;

  localparam int unsigned SEL_W   = 2;
  localparam int unsigned NUM_OUT = 4;

  localparam logic [SEL_W-1:0] SEL_O0 = 2'b00;
  localparam logic [SEL_W-1:0] SEL_O1 = 2'b01;
  localparam logic [SEL_W-1:0] SEL_O2 = 2'b10;
  localparam logic [SEL_W-1:0] SEL_O3 = 2'b11;

endpackage

// File: rtl/demux_sel_decoder.sv
// Combinational 2-to-4 one-hot decoder turning a channel select into per-port enables.
module demux_sel_decoder
  import demux_pkg::*;
(
  input  logic [SEL_W-1:0]   sel,
  output logic [NUM_OUT-1:0] en
);

  always_comb begin
    en = '0;
    unique case (sel)
      SEL_O0:  en = 4'b0001;
      SEL_O1:  en = 4'b0010;
      SEL_O2:  en = 4'b0100;
      SEL_O3:  en = 4'b1000;
      default: en = '0;
    endcase
  end

endmodule

// File: rtl/demux_1to4_data.sv
// 1-to-4 data demultiplexer: routes i to the selected output register, zeroes the
// other three, one cycle of latency.
module demux_1to4_data
  import demux_pkg::*;
#(
  parameter int unsigned width = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [width-1:0] i,
  input  logic [SEL_W-1:0] sel,
  output logic [width-1:0] o0,
  output logic [width-1:0] o1,
  output logic [width-1:0] o2,
  output logic [width-1:0] o3
);

  logic [NUM_OUT-1:0] en;
  logic [width-1:0]   o0_d, o1_d, o2_d, o3_d;

  demux_sel_decoder u_sel_decoder (
    .sel (sel),
    .en  (en)
  );

  // Unselected ports load zero so only one port ever holds data.
  always_comb begin
    o0_d = en[0] ? i : '0;
    o1_d = en[1] ? i : '0;
    o2_d = en[2] ? i : '0;
    o3_d = en[3] ? i : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o0 <= '0;
      o1 <= '0;
      o2 <= '0;
      o3 <= '0;
    end else begin
      o0 <= o0_d;
      o1 <= o1_d;
      o2 <= o2_d;
      o3 <= o3_d;
    end
  end

endmodule

// File: tb/tb_demux_1to4_data.sv
// Bench for demux_1to4_data: directed table, hand-written reset/latency sequences and
// random traffic against a port-array model, on width=2 and width=8 instances.
module tb_demux_1to4_data;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] i, sel;
  logic [1:0] o0, o1, o2, o3;
  logic [7:0] i8;
  logic [1:0] sel8;
  logic [7:0] p0, p1, p2, p3;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  demux_1to4_data #(.width(2)) dut (
    .clk (clk), .rst_n (rst_n), .i (i), .sel (sel),
    .o0 (o0), .o1 (o1), .o2 (o2), .o3 (o3)
  );

  demux_1to4_data #(.width(8)) dut8 (
    .clk (clk), .rst_n (rst_n), .i (i8), .sel (sel8),
    .o0 (p0), .o1 (p1), .o2 (p2), .o3 (p3)
  );

  typedef struct {
    logic [1:0] i;
    logic [1:0] sel;
    logic [1:0] e0, e1, e2, e3;
  } vec_t;

  vec_t tbl[4];

  // Reference: a bank of four ports, all cleared, then the selected one gets the data.
  logic [1:0] m[4];
  logic [7:0] m8[4];

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_all(input string tag, input logic [1:0] e0, input logic [1:0] e1,
                           input logic [1:0] e2, input logic [1:0] e3);
    chk({tag, ".o0"}, {6'd0, o0}, {6'd0, e0});
    chk({tag, ".o1"}, {6'd0, o1}, {6'd0, e1});
    chk({tag, ".o2"}, {6'd0, o2}, {6'd0, e2});
    chk({tag, ".o3"}, {6'd0, o3}, {6'd0, e3});
  endtask

  initial begin
    tbl[0] = '{i: 2'b01, sel: 2'b00, e0: 2'b01, e1: 2'b00, e2: 2'b00, e3: 2'b00};
    tbl[1] = '{i: 2'b10, sel: 2'b01, e0: 2'b00, e1: 2'b10, e2: 2'b00, e3: 2'b00};
    tbl[2] = '{i: 2'b11, sel: 2'b10, e0: 2'b00, e1: 2'b00, e2: 2'b11, e3: 2'b00};
    tbl[3] = '{i: 2'b01, sel: 2'b11, e0: 2'b00, e1: 2'b00, e2: 2'b00, e3: 2'b01};

    rst_n = 1'b0;
    i     = 2'b11;
    sel   = 2'b01;
    i8    = 8'h00;
    sel8  = 2'b00;

    // Reset held across edges with live inputs.
    repeat (2) begin
      @(posedge clk); #1;
      check_all("rst_hold", 2'b00, 2'b00, 2'b00, 2'b00);
      chk("rst_hold.w8.o0", p0, 8'h00);
    end
    @(negedge clk) rst_n = 1'b1;

    // Directed sweep, each vector held three cycles.
    foreach (tbl[v]) begin
      @(negedge clk);
      i   = tbl[v].i;
      sel = tbl[v].sel;
      for (int c = 0; c < 3; c++) begin
        @(posedge clk); #1;
        check_all($sformatf("sweep%0d.c%0d", v, c), tbl[v].e0, tbl[v].e1, tbl[v].e2, tbl[v].e3);
      end
    end

    // Select change just after an edge takes effect only at the next edge.
    @(negedge clk);
    i   = 2'b11;
    sel = 2'b00;
    @(posedge clk); #1;
    check_all("lat_pre", 2'b11, 2'b00, 2'b00, 2'b00);
    sel = 2'b10;
    #2;
    check_all("lat_between", 2'b11, 2'b00, 2'b00, 2'b00);
    @(posedge clk); #1;
    check_all("lat_post", 2'b00, 2'b00, 2'b11, 2'b00);

    // Zero data.
    @(negedge clk);
    i   = 2'b00;
    sel = 2'b01;
    @(posedge clk); #1;
    check_all("zero_data", 2'b00, 2'b00, 2'b00, 2'b00);

    // Mid-operation asynchronous reset pulse.
    @(negedge clk);
    i   = 2'b11;
    sel = 2'b10;
    @(posedge clk); #1;
    check_all("mid_pre", 2'b00, 2'b00, 2'b11, 2'b00);
    #2 rst_n = 1'b0;
    #1 check_all("mid_async", 2'b00, 2'b00, 2'b00, 2'b00);
    #1 rst_n = 1'b1;
    i   = 2'b10;
    sel = 2'b10;
    #1 check_all("mid_release", 2'b00, 2'b00, 2'b00, 2'b00);
    @(posedge clk); #1;
    check_all("mid_first_edge", 2'b00, 2'b00, 2'b10, 2'b00);

    // Wide instance.
    @(negedge clk);
    i8   = 8'hA5;
    sel8 = 2'b11;
    @(posedge clk); #1;
    chk("w8.o0", p0, 8'h00);
    chk("w8.o1", p1, 8'h00);
    chk("w8.o2", p2, 8'h00);
    chk("w8.o3", p3, 8'hA5);

    // Random traffic against the port-array model.
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      i    = 2'($urandom_range(0, 3));
      sel  = 2'($urandom_range(0, 3));
      i8   = 8'($urandom_range(0, 255));
      sel8 = 2'($urandom_range(0, 3));
      @(posedge clk);
      m  = '{default: 2'b00};
      m8 = '{default: 8'h00};
      m[sel]   = i;
      m8[sel8] = i8;
      #1;
      check_all($sformatf("rnd%0d", n), m[0], m[1], m[2], m[3]);
      chk($sformatf("rnd%0d.w8.o0", n), p0, m8[0]);
      chk($sformatf("rnd%0d.w8.o1", n), p1, m8[1]);
      chk($sformatf("rnd%0d.w8.o2", n), p2, m8[2]);
      chk($sformatf("rnd%0d.w8.o3", n), p3, m8[3]);
      chk($sformatf("rnd%0d.nonzero_ports", n),
          8'((o0 != 0) + (o1 != 0) + (o2 != 0) + (o3 != 0)), 8'(i != 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
